// File: rtl/pong_game_if.sv
// Pong match sequencer bus: player inputs toward the controller, match status back out.
interface pong_game_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic               point1;
  logic               point2;
  logic               serve;
  logic               serve_right;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [2:0]         state;
  logic               game_over;
  logic               winner;

  modport master (
    output start, point1, point2,
    input  serve, serve_right, score1, score2, state, game_over, winner
  );

  modport slave (
    input  start, point1, point2,
    output serve, serve_right, score1, score2, state, game_over, winner
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serves the ball, keeps both scores, holds a fixed
// pause between points and stops the match when a player reaches WIN_SCORE.
//
// state | meaning
// IDLE  | waiting for the first start press after reset
// PLAY  | ball in play, waiting for a point pulse
// PAUSE | ball held at centre for PAUSE_CLKS cycles before the next serve
// OVER  | match finished, scores and winner frozen until start is pressed
module pong_game_ctrl #(
  parameter int WIN_SCORE  = 7,
  parameter int PAUSE_CLKS = 25_000_000,
  parameter int SCORE_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  pong_game_if.slave bus
);

  localparam int TIMER_W = $clog2(PAUSE_CLKS + 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PAUSE_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    OVER  = 3'd3
  } state_t;

  // Kept as a plain vector so encodings 4..7 stay representable and recoverable.
  logic [2:0]         state_q;
  state_t             state_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               serve_q, serve_d;
  logic               serve_right_q, serve_right_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               start_q;
  logic               start_rise;
  logic [SCORE_W-1:0] inc1, inc2;

  assign start_rise = bus.start & ~start_q;
  assign inc1       = score1_q + 1'b1;
  assign inc2       = score2_q + 1'b1;

  // State and all registered outputs; reset forces the idle/cleared picture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      score1_q      <= '0;
      score2_q      <= '0;
      timer_q       <= '0;
      serve_q       <= 1'b0;
      serve_right_q <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      timer_q       <= timer_d;
      serve_q       <= serve_d;
      serve_right_q <= serve_right_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      start_q       <= bus.start;
    end
  end

  // Next-state and next-output decisions; serve only rises on a PLAY entry.
  always_comb begin
    state_d       = IDLE;
    score1_d      = score1_q;
    score2_d      = score2_q;
    timer_d       = timer_q;
    serve_d       = 1'b0;
    serve_right_d = serve_right_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    case (state_q)
      IDLE, OVER: begin
        state_d = (state_q == OVER) ? OVER : IDLE;
        if (start_rise) begin
          state_d       = PLAY;
          score1_d      = '0;
          score2_d      = '0;
          serve_right_d = 1'b1;
          game_over_d   = 1'b0;
          serve_d       = 1'b1;
        end
      end
      PLAY: begin
        state_d = PLAY;
        // point1 takes priority when both pulses land in the same cycle.
        if (bus.point1 || bus.point2) begin
          if (bus.point1) score1_d = inc1;
          else            score2_d = inc2;
          if ((bus.point1 && inc1 == WIN_S) || (!bus.point1 && inc2 == WIN_S)) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = ~bus.point1;
          end else begin
            state_d       = PAUSE;
            timer_d       = '0;
            serve_right_d = bus.point1;
          end
        end
      end
      PAUSE: begin
        state_d = PAUSE;
        if (timer_q == TIMER_LAST) begin
          state_d = PLAY;
          serve_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        timer_d     = '0;
        game_over_d = 1'b0;
      end
    endcase
  end

  assign bus.state       = state_q;
  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;
  assign bus.serve       = serve_q;
  assign bus.serve_right = serve_right_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl with WIN_SCORE=3, PAUSE_CLKS=4.
module tb_pong_game_ctrl;
  localparam int WIN   = 3;
  localparam int PAUSE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_pass = 0;

  pong_game_if #(.SCORE_W(4)) bus();

  pong_game_ctrl #(.WIN_SCORE(WIN), .PAUSE_CLKS(PAUSE), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: match phase, scores, and remaining pause cycles.
  int m_mode, m_s1, m_s2, m_left;
  bit m_sr, m_go, m_win, m_serve, m_startq;

  function automatic void model_reset();
    m_mode = 0; m_s1 = 0; m_s2 = 0; m_left = 0;
    m_sr = 1; m_go = 0; m_win = 0; m_serve = 0; m_startq = 0;
  endfunction

  function automatic void model_step(bit st, bit p1, bit p2);
    bit rise;
    rise = st && !m_startq;
    m_startq = st;
    m_serve = 0;
    if (m_mode == 0 || m_mode == 3) begin
      if (rise) begin
        m_s1 = 0; m_s2 = 0; m_sr = 1; m_go = 0; m_mode = 1; m_serve = 1;
      end
    end else if (m_mode == 1) begin
      if (p1 || p2) begin
        if (p1) m_s1++; else m_s2++;
        if (m_s1 == WIN || m_s2 == WIN) begin
          m_mode = 3; m_go = 1; m_win = (m_s2 == WIN);
        end else begin
          m_mode = 2; m_left = PAUSE; m_sr = p1;
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin m_mode = 1; m_serve = 1; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.point1 = 1'b0; bus.point2 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start_match();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.state, bus.score1, bus.score2} !== 11'd0) $display("FAIL reset_state_scores: got %h want 0", {bus.state, bus.score1, bus.score2});
    else n_pass++;
    n_checks++;
    if ({bus.serve, bus.serve_right, bus.game_over, bus.winner} !== 4'b0100) $display("FAIL reset_flags: got %b want 0100", {bus.serve, bus.serve_right, bus.game_over, bus.winner});
    else n_pass++;
  endtask

  task automatic test_start();
    do_reset();
    bus.start = 1'b1;
    tick();
    n_checks++;
    if (bus.state !== 3'd1 || bus.serve !== 1'b1) $display("FAIL start_serve: got state=%0d serve=%b want 1/1", bus.state, bus.serve);
    else n_pass++;
    n_checks++;
    if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.serve_right !== 1'b1) $display("FAIL start_clear: got %0d %0d sr=%b want 0 0 1", bus.score1, bus.score2, bus.serve_right);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.serve !== 1'b0 || bus.state !== 3'd1) $display("FAIL start_held: got serve=%b state=%0d want 0/1", bus.serve, bus.state);
      else n_pass++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_point_pause();
    bus.point2 = 1'b1;
    tick();
    bus.point2 = 1'b0;
    n_checks++;
    if (bus.score2 !== 4'd1 || bus.state !== 3'd2 || bus.serve_right !== 1'b0) $display("FAIL point2_pause: got s2=%0d state=%0d sr=%b want 1 2 0", bus.score2, bus.state, bus.serve_right);
    else n_pass++;
    for (int i = 2; i <= 4; i++) begin
      tick();
      n_checks++;
      if (bus.serve !== 1'b0 || bus.state !== 3'd2) $display("FAIL pause_hold: cycle N+%0d got serve=%b state=%0d want 0/2", i, bus.serve, bus.state);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (bus.serve !== 1'b1 || bus.state !== 3'd1) $display("FAIL pause_serve: got serve=%b state=%0d want 1/1", bus.serve, bus.state);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.serve !== 1'b0) $display("FAIL serve_width: got %b want 0", bus.serve);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_match();
    bus.point1 = 1'b1; bus.point2 = 1'b1;
    tick();
    n_checks++;
    if (bus.score1 !== 4'd1 || bus.score2 !== 4'd0 || bus.serve_right !== 1'b1) $display("FAIL both_points: got %0d %0d sr=%b want 1 0 1", bus.score1, bus.score2, bus.serve_right);
    else n_pass++;
    bus.start = 1'b1;
    tick();
    bus.point1 = 1'b0; bus.point2 = 1'b0; bus.start = 1'b0;
    n_checks++;
    if (bus.score1 !== 4'd1 || bus.score2 !== 4'd0 || bus.serve !== 1'b0 || bus.state !== 3'd2) $display("FAIL pause_ignore: got %0d %0d serve=%b state=%0d want 1 0 0 2", bus.score1, bus.score2, bus.serve, bus.state);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (bus.serve !== 1'b0) $display("FAIL early_serve: got %b want 0", bus.serve);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.serve !== 1'b1) $display("FAIL late_serve: got %b want 1", bus.serve);
    else n_pass++;
  endtask

  task automatic test_match_over();
    do_reset();
    start_match();
    for (int i = 0; i < WIN; i++) begin
      bus.point1 = 1'b1;
      tick();
      bus.point1 = 1'b0;
      if (i < WIN - 1) begin
        tick(); tick(); tick(); tick();
        n_checks++;
        if (bus.serve !== 1'b1) $display("FAIL rally_serve_%0d: got %b want 1", i, bus.serve);
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.score1 !== 4'd3 || bus.state !== 3'd3 || bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.serve !== 1'b0)
      $display("FAIL match_over: got s1=%0d state=%0d go=%b win=%b serve=%b want 3 3 1 0 0", bus.score1, bus.state, bus.game_over, bus.winner, bus.serve);
    else n_pass++;
    bus.point2 = 1'b1;
    tick(); tick();
    bus.point2 = 1'b0;
    n_checks++;
    if (bus.score2 !== 4'd0 || bus.state !== 3'd3 || bus.serve !== 1'b0) $display("FAIL over_frozen: got s2=%0d state=%0d serve=%b want 0 3 0", bus.score2, bus.state, bus.serve);
    else n_pass++;
    start_match();
    n_checks++;
    if (bus.score1 !== 4'd0 || bus.game_over !== 1'b0 || bus.serve !== 1'b1 || bus.state !== 3'd1)
      $display("FAIL restart: got s1=%0d go=%b serve=%b state=%0d want 0 0 1 1", bus.score1, bus.game_over, bus.serve, bus.state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pause();
    do_reset();
    start_match();
    bus.point1 = 1'b1;
    tick();
    bus.point1 = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.state !== 3'd0 || bus.score1 !== 4'd0 || bus.serve !== 1'b0) $display("FAIL reset_async: got state=%0d s1=%0d serve=%b want 0 0 0", bus.state, bus.score1, bus.serve);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (bus.serve !== 1'b0 || bus.state !== 3'd0) $display("FAIL after_reset_idle: got serve=%b state=%0d want 0/0", bus.serve, bus.state);
      else n_pass++;
    end
  endtask

  task automatic test_illegal_state();
    do_reset();
    start_match();
    bus.point2 = 1'b1;
    tick();
    bus.point2 = 1'b0;
    tick(); tick(); tick(); tick();
    force dut.state_q = 3'd5;
    #1;
    release dut.state_q;
    tick();
    n_checks++;
    if (bus.state !== 3'd0 || bus.serve !== 1'b0 || bus.score2 !== 4'd1 || bus.score1 !== 4'd0)
      $display("FAIL illegal_recover: got state=%0d serve=%b s1=%0d s2=%0d want 0 0 0 1", bus.state, bus.serve, bus.score1, bus.score2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [14:0] exp_v, act_v;
    bit st, p1, p2;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      st = ($urandom_range(0, 7) == 0);
      p1 = ($urandom_range(0, 5) == 0);
      p2 = ($urandom_range(0, 4) == 0);
      bus.start = st; bus.point1 = p1; bus.point2 = p2;
      tick();
      model_step(st, p1, p2);
      exp_v = {3'(m_mode), 4'(m_s1), 4'(m_s2), m_serve, m_sr, m_go, m_win};
      act_v = {bus.state, bus.score1, bus.score2, bus.serve, bus.serve_right, bus.game_over, bus.winner};
      n_checks++;
      if (act_v !== exp_v) $display("FAIL random_cycle_%0d: got %h want %h", c, act_v, exp_v);
      else n_pass++;
    end
    bus.start = 1'b0; bus.point1 = 1'b0; bus.point2 = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.point1 = 1'b0; bus.point2 = 1'b0;
    test_reset();
    test_start();
    test_point_pause();
    test_simultaneous();
    test_match_over();
    test_reset_mid_pause();
    test_illegal_state();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
